distributor_16: RTL and testbench

Two-output 16-bit stream distributor, the inverse of the 16-bit 2:1 selector. One valid/ready input stream is routed beat by beat to output channel 0 or 1 according to a per-beat `sel` bit. Each output has its own 2-entry buffer, so a stalled consumer on one channel never blocks beats headed for the other. It sits between the processor's result bus and two downstream consumers, for example the register-file writeback and the store path.

---
 rtl/distributor_pkg.sv | 12 +
 rtl/distributor_16_fifo2.sv | 67 ++++++
 rtl/distributor_16.sv | 66 ++++++
 tb/tb_distributor_16.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/distributor_pkg.sv
// Shared definitions for the two-output stream distributor.
//   WIDTH  : payload width of every data port
//   DEPTH  : entries per output buffer (fixed at 2)
//   word_t : one payload word
//   cnt_t  : buffer occupancy, 0..DEPTH
package distributor_pkg;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [1:0]       cnt_t;
endpackage

// File: rtl/distributor_16_fifo2.sv
// fifo2_16: 2-entry circular FIFO used as one output buffer of the distributor.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full)
//   push_data  : word to store
//   pop        : retire the head entry (ignored when empty)
//   full       : both entries occupied
//   empty      : no entries occupied
//   head_data  : entry at the read pointer, straight from storage
module fifo2_16
    import distributor_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output word_t head_data
);

    word_t entry0;
    word_t entry1;
    logic  wr_ptr;
    logic  rd_ptr;
    cnt_t  count;

    logic  do_push;
    logic  do_pop;

    assign full  = (count == cnt_t'(DEPTH));
    assign empty = (count == 2'd0);

    // A full buffer refuses the push even while popping, so the producer's
    // ready never has to look at the consumer's ready.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head selection depends only on registered state.
    assign head_data = rd_ptr ? entry1 : entry0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) entry1 <= push_data;
                else        entry0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/distributor_16.sv
// distributor_16: routes one valid/ready stream beat by beat to channel 0 or 1
// according to in_sel. Each channel has its own 2-entry buffer so a stalled
// consumer on one channel never blocks the other.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid, in_sel, in_data        : input beat, destination, payload
//   in_ready                         : beat accepted this cycle
//   out0_valid, out0_data, out0_ready: channel 0 handshake
//   out1_valid, out1_data, out1_ready: channel 1 handshake
module distributor_16
    import distributor_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  logic  in_sel,
    input  word_t in_data,
    output logic  in_ready,
    output logic  out0_valid,
    output word_t out0_data,
    input  logic  out0_ready,
    output logic  out1_valid,
    output word_t out1_data,
    input  logic  out1_ready
);

    logic acc;
    logic push0;
    logic push1;
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;

    // Ready depends only on in_sel and registered occupancy.
    assign in_ready = in_sel ? !full1 : !full0;
    assign acc      = in_valid && in_ready;
    assign push0    = acc && !in_sel;
    assign push1    = acc && in_sel;

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    fifo2_16 u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .empty     (empty0),
        .head_data (out0_data)
    );

    fifo2_16 u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .empty     (empty1),
        .head_data (out1_data)
    );

endmodule

// File: tb/tb_distributor_16.sv
// Self-checking bench for distributor_16: per-channel queue model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_distributor_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sel;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out0_valid;
    logic [15:0] out0_data;
    logic        out0_ready;
    logic        out1_valid;
    logic [15:0] out1_data;
    logic        out1_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    distributor_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO queue per channel, capacity 2.
    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            bit pop0, pop1, acc;
            pop0 = (q0.size() > 0) && out0_ready;
            pop1 = (q1.size() > 0) && out1_ready;
            acc  = in_valid && (in_sel ? (q1.size() < 2) : (q0.size() < 2));
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
            chk("m_out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) chk("m_out0_data", {16'd0, out0_data}, {16'd0, q0[0]});
            if (q1.size() != 0) chk("m_out1_data", {16'd0, out1_data}, {16'd0, q1[0]});
            chk("m_in_ready", {31'd0, in_ready},
                {31'd0, in_sel ? (q1.size() < 2) : (q0.size() < 2)});
        end
    end

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // Advance one clock; returns 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state and ready after release.
        #1;
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data", {16'd0, out0_data}, 32'h0);
        chk("rst_ready_sel0", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1 chk("rst_ready_sel1", {31'd0, in_ready}, 32'd1);
        tick();

        // Basic routing.
        drive(1, 0, 16'hAAAA, 1, 1);
        tick();
        chk("route_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("route_out0_data", {16'd0, out0_data}, 32'hAAAA);
        chk("route_out1_quiet", {31'd0, out1_valid}, 32'd0);
        drive(1, 1, 16'hBBBB, 1, 1);
        tick();
        chk("route_out1_valid", {31'd0, out1_valid}, 32'd1);
        chk("route_out1_data", {16'd0, out1_data}, 32'hBBBB);
        chk("route_out0_drained", {31'd0, out0_valid}, 32'd0);
        drive(0, 0, 16'h0, 1, 1);
        tick();
        chk("route_out1_drained", {31'd0, out1_valid}, 32'd0);

        // Backpressure on channel 0.
        drive(1, 0, 16'h1111, 0, 1);
        tick();
        drive(1, 0, 16'h2222, 0, 1);
        tick();
        drive(1, 0, 16'h3333, 0, 1);
        #1 chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_head_held", {16'd0, out0_data}, 32'h1111);

        // Independence: channel 1 still accepts while channel 0 is stalled.
        drive(1, 1, 16'hCCCC, 0, 0);
        #1 chk("ind_ready_sel1", {31'd0, in_ready}, 32'd1);
        tick();
        chk("ind_out1_data", {16'd0, out1_data}, 32'hCCCC);
        chk("ind_out0_stalled", {16'd0, out0_data}, 32'h1111);

        // Drain channel 0; 3333 is taken the cycle after the first pop.
        drive(1, 0, 16'h3333, 1, 1);
        #1 chk("bp_ready_popping", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_drain_2222", {16'd0, out0_data}, 32'h2222);
        #1 chk("bp_ready_freed", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drain_3333", {16'd0, out0_data}, 32'h3333);
        drive(0, 0, 16'h0, 1, 1);
        tick();
        chk("bp_empty", {31'd0, out0_valid}, 32'd0);

        // Streaming with simultaneous push/pop across pointer wrap.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 16'(i), 1, 1);
            #1 chk("wrap_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("wrap_data", {16'd0, out1_data}, i);
        end
        drive(0, 0, 16'h0, 1, 1);
        tick();
        chk("wrap_empty", {31'd0, out1_valid}, 32'd0);

        // Alternating destinations with toggling consumer readiness.
        for (int i = 0; i < 40; i++) begin
            drive(1, i[0], 16'h5000 + 16'(i), i[1] ^ i[3], i[2] | i[4]);
            tick();
        end
        drive(0, 0, 16'h0, 1, 1);
        repeat (4) tick();
        chk("mix_out0_drained", {31'd0, out0_valid}, 32'd0);
        chk("mix_out1_drained", {31'd0, out1_valid}, 32'd0);

        // Reset mid-transfer drops everything without a clock edge.
        drive(1, 0, 16'hDEAD, 0, 0);
        tick();
        drive(1, 1, 16'hBEEF, 0, 0);
        tick();
        chk("pre_rst_out0", {16'd0, out0_data}, 32'hDEAD);
        rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("arst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("arst_out0_data", {16'd0, out0_data}, 32'h0);
        chk("arst_out1_data", {16'd0, out1_data}, 32'h0);
        drive(0, 0, 16'h0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1 chk("arst_ready_after", {31'd0, in_ready}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
